// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - bus between the branch/flow-control stage and its driver/PC block
// Inputs come from the instruction/ALU side; outputs feed the PC block.
interface branch_ctrl_if #(
  parameter int PC_W  = 7,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
);
  logic             start;
  logic [8:0]       instr;
  logic             flag_we;
  logic             alu_zero;
  logic             lut_we;
  logic [IDX_W-1:0] lut_addr;
  logic [PC_W-1:0]  lut_wdata;
  logic             branch;
  logic             branch_conditional;
  logic             zero;
  logic [PC_W-1:0]  target;
  logic             pc_hold;
  logic             done;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output start, instr, flag_we, alu_zero, lut_we, lut_addr, lut_wdata,
    input  branch, branch_conditional, zero, target, pc_hold, done, taken_cnt
  );

  modport slave (
    input  start, instr, flag_we, alu_zero, lut_we, lut_addr, lut_wdata,
    output branch, branch_conditional, zero, target, pc_hold, done, taken_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch decode, zero flag, target LUT, run/halt FSM and taken-branch counter
// Branch outputs are combinational so the PC block can act on them at the next edge.
module branch_ctrl #(
  parameter int PC_W  = 7,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  branch_ctrl_if.slave  bus
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  lut_q [DEPTH];

  logic [2:0] opcode;
  logic       is_halt, is_br, is_brz, running, accept_start, taken;

  assign opcode       = bus.instr[8:6];
  assign is_halt      = (bus.instr == 9'h1FF);
  assign is_br        = (opcode == 3'b110);
  assign is_brz       = (opcode == 3'b111) && !is_halt;
  assign running      = (state_q == S_RUN);
  assign accept_start = bus.start && !running;
  // BRZ uses the registered flag, so a same-cycle flag write is not seen
  assign taken        = running && (is_br || (is_brz && zero_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (is_halt)   state_d = S_DONE;
      S_DONE:  if (bus.start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    zero_d = zero_q;
    cnt_d  = cnt_q;
    if (bus.flag_we) zero_d = bus.alu_zero;
    if (accept_start) begin
      cnt_d = '0;
    end else if (taken && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= '0;
    end else if (bus.lut_we) begin
      lut_q[bus.lut_addr] <= bus.lut_wdata;
    end
  end

  assign bus.branch             = running && (is_br || is_brz);
  assign bus.branch_conditional = running && is_brz;
  assign bus.zero               = zero_q;
  assign bus.target             = lut_q[bus.instr[IDX_W-1:0]];
  assign bus.pc_hold            = !running;
  assign bus.done               = (state_q == S_DONE);
  assign bus.taken_cnt          = cnt_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - scoreboard bench for branch_ctrl (default and 2-bit counter instances)
module tb_branch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  branch_ctrl_if bi ();
  branch_ctrl_if #(.CNT_W(2)) bs ();

  assign bs.start     = bi.start;
  assign bs.instr     = bi.instr;
  assign bs.flag_we   = bi.flag_we;
  assign bs.alu_zero  = bi.alu_zero;
  assign bs.lut_we    = bi.lut_we;
  assign bs.lut_addr  = bi.lut_addr;
  assign bs.lut_wdata = bi.lut_wdata;

  branch_ctrl dut (.clk(clk), .reset(reset), .bus(bi));
  branch_ctrl #(.CNT_W(2)) dut_sat (.clk(clk), .reset(reset), .bus(bs));

  typedef struct {
    logic        branch;
    logic        bcond;
    logic        zero;
    logic [6:0]  target;
    logic        pc_hold;
    logic        done;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int step_no = 0;

  int          m_state;
  logic        m_zero;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  logic [6:0]  m_lut [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", tag, step_no, got, want);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_zero  = 1'b0;
    m_cnt   = '0;
    m_cnt2  = '0;
    for (int i = 0; i < 32; i++) m_lut[i] = '0;
  endtask

  function automatic exp_t predict(input logic [8:0] ins);
    exp_t e;
    logic halt, br, brz, run;
    halt = (ins == 9'h1FF);
    br   = (ins[8:6] == 3'b110);
    brz  = (ins[8:6] == 3'b111) && !halt;
    run  = (m_state == 1);
    e.branch  = run && (br || brz);
    e.bcond   = run && brz;
    e.zero    = m_zero;
    e.target  = m_lut[ins[4:0]];
    e.pc_hold = !run;
    e.done    = (m_state == 2);
    e.cnt     = m_cnt;
    e.cnt2    = m_cnt2;
    return e;
  endfunction

  task automatic pop_compare();
    exp_t e;
    e = exp_q.pop_front();
    check("branch",    32'(bi.branch),             32'(e.branch));
    check("bcond",     32'(bi.branch_conditional), 32'(e.bcond));
    check("zero",      32'(bi.zero),               32'(e.zero));
    check("target",    32'(bi.target),             32'(e.target));
    check("pc_hold",   32'(bi.pc_hold),            32'(e.pc_hold));
    check("done",      32'(bi.done),               32'(e.done));
    check("taken_cnt", 32'(bi.taken_cnt),          32'(e.cnt));
    check("sat_cnt",   32'(bs.taken_cnt),          32'(e.cnt2));
    check("sat_pc_hold", 32'(bs.pc_hold),          32'(e.pc_hold));
  endtask

  task automatic step(input logic st, input logic [8:0] ins, input logic fwe, input logic az,
                      input logic lwe, input logic [4:0] la, input logic [6:0] lw);
    logic halt, br, brz, run, taken;
    @(negedge clk);
    step_no++;
    bi.start = st; bi.instr = ins; bi.flag_we = fwe; bi.alu_zero = az;
    bi.lut_we = lwe; bi.lut_addr = la; bi.lut_wdata = lw;
    exp_q.push_back(predict(ins));
    #1;
    pop_compare();
    halt  = (ins == 9'h1FF);
    br    = (ins[8:6] == 3'b110);
    brz   = (ins[8:6] == 3'b111) && !halt;
    run   = (m_state == 1);
    taken = run && (br || (brz && m_zero));
    if (!run && st) begin
      m_state = 1; m_cnt = '0; m_cnt2 = '0;
    end else begin
      if (run && halt) m_state = 2;
      if (taken) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
    end
    if (fwe) m_zero = az;
    if (lwe) m_lut[la] = lw;
  endtask

  task automatic nop();
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
  endtask

  localparam logic [8:0] BR3  = 9'b110_000011;
  localparam logic [8:0] BRZ4 = 9'b111_000100;
  localparam logic [8:0] BR5  = 9'b110_000101;
  localparam logic [8:0] HALT = 9'h1FF;

  initial begin
    logic [8:0] ri;
    bi.start = 1'b0; bi.instr = '0; bi.flag_we = 1'b0; bi.alu_zero = 1'b0;
    bi.lut_we = 1'b0; bi.lut_addr = '0; bi.lut_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    nop();
    nop();
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 5'd3, 7'h0F);
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 5'd4, 7'h14);
    step(1'b0, BR3, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b0, BR3, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    nop();
    step(1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 5'd0, 7'd0);
    step(1'b0, BRZ4, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b0, BRZ4, 1'b1, 1'b1, 1'b0, 5'd0, 7'd0);
    nop();
    step(1'b1, BR3, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b0, BR3, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b0, BR3, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b0, BR5, 1'b0, 1'b0, 1'b1, 5'd5, 7'h22);
    step(1'b0, BR5, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b0, HALT, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b0, BR3, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    step(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    nop();

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       ri = HALT;
        1, 2:    ri = {3'b110, 6'($urandom_range(0, 63))};
        3, 4:    ri = {3'b111, 6'($urandom_range(0, 62))};
        default: ri = 9'($urandom_range(0, 383));
      endcase
      step(1'($urandom_range(0, 5) == 0), ri, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)));
    end

    step(1'b1, 9'h000, 1'b1, 1'b1, 1'b0, 5'd0, 7'd0);
    step(1'b0, BR5, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
    @(negedge clk);
    step_no++;
    bi.instr = BR5;
    bi.start = 1'b0; bi.flag_we = 1'b0; bi.lut_we = 1'b0;
    reset = 1'b0;
    model_reset();
    exp_q.push_back(predict(BR5));
    #1;
    pop_compare();
    @(negedge clk);
    reset = 1'b1;
    nop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Branch/flow-control stage directly upstream of the program counter block. It decodes the current 9-bit instruction and owns the zero-flag register, a programmable 32-entry branch-target LUT, a run/halt state machine and a taken-branch counter. It drives the PC block's branch, branch_conditional, zero and target inputs, plus a pc_hold enable. The PC block registers them on the next clk edge.

Parameters:
PC_W, 7, width of program counter / branch target
IDX_W, 5, LUT index width (2**IDX_W entries)
CNT_W, 16, taken-branch counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; clears all state
start  input  1  single-cycle pulse; IDLE/DONE -> RUN
instr  input  9  instruction at current PC
flag_we  input  1  ALU result valid this cycle; load zero flag
alu_zero  input  1  ALU result == 0
lut_we  input  1  LUT write enable
lut_addr  input  IDX_W  LUT write index
lut_wdata  input  PC_W  LUT write data
branch  output  1  branch request to PC block
branch_conditional  output  1  branch is BRZ
zero  output  1  registered zero flag
target  output  PC_W  LUT[instr[4:0]]
pc_hold  output  1  PC block must not advance
done  output  1  high in DONE state
taken_cnt  output  CNT_W  count of taken branches since start

Behaviour:
- Decode: opcode = instr[8:6].
  - HALT = instr == 9'h1FF (overrides BRZ).
  - BR = opcode 3'b110.
  - BRZ = opcode 3'b111 and not HALT.
  - All other opcodes are non-branch.
- FSM states: IDLE, RUN, DONE. Reset -> IDLE.
  - IDLE: start -> RUN.
  - RUN: HALT decoded -> DONE. start is ignored in RUN.
  - DONE: start -> RUN.
- Outputs per state:
  - pc_hold = 1 in IDLE and DONE, 0 in RUN.
  - done = (state == DONE), registered.
- Branch outputs are combinational from instr and state.
  - In RUN: branch = BR|BRZ; branch_conditional = BRZ.
  - Otherwise (IDLE, DONE, or HALT instruction): both 0.
- target = LUT[instr[IDX_W-1:0]], combinational read, driven in every state.
- Zero flag:
  - On a clk edge with flag_we=1, zero <= alu_zero, in any state.
  - A BRZ evaluated in the same cycle as flag_we sees the old (registered) flag.
  - Reset value 0.
- LUT:
  - Synchronous write, asynchronous read.
  - Reading the same index in the same cycle as a write returns the old value; the new value is visible next cycle.
  - All entries reset to 0.
- taken_cnt:
  - Increments on a clk edge when state==RUN and (BR, or BRZ with zero==1).
  - Saturates at all-ones; no wrap.
  - Cleared to 0 on the clk edge that accepts start (IDLE/DONE -> RUN).
  - Reset value 0.
- Reset values: state IDLE, pc_hold=1, done=0, branch=0, branch_conditional=0, zero=0, taken_cnt=0, target=0.
- Reset mid-operation: asynchronous; outputs take reset values immediately, without waiting for a clock edge.
- Latency: branch decisions take 0 cycles (same cycle as instr). The PC update happens at the next edge in the PC block.

Test Plan:
- Reset values: hold reset=0 for 2 cycles, release, no start -> pc_hold=1, done=0, branch=0, zero=0, taken_cnt=0.
- Unconditional branch: LUT[3]=7'h0F, start, instr=9'b110_000011 -> branch=1, branch_conditional=0, target=0F; taken_cnt=1 after edge.
- BRZ taken: flag_we=1, alu_zero=1 (one cycle), then LUT[4]=7'h14, instr=9'b111_000100 -> branch=1, branch_conditional=1, zero=1, target=14; taken_cnt increments.
- BRZ not taken, with same-cycle flag write: zero=0, instr=9'b111_000100, flag_we=1, alu_zero=1 that same cycle -> taken_cnt unchanged, zero=1 after edge.
- HALT and restart: instr=9'h1FF in RUN -> branch=0 that cycle; after edge done=1, pc_hold=1. start pulse -> RUN, done=0, taken_cnt=0.
- LUT write/read collision, counter saturation, async reset: write LUT[5]=7'h22 while instr indexes 5 -> target shows old value that cycle, 22 next cycle. With CNT_W=2 and 5 taken branches -> taken_cnt=3. reset asserted mid-RUN between edges -> pc_hold=1 and state IDLE immediately.
